// File: rtl/ques2_pkg.sv
// Shared types and constants for the QUES2 sweep driver and its dwell timer.
package ques2_pkg;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;
  localparam int ERR_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FIN   = 2'd2
  } state_e;

  function automatic logic is_last_vec(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_VEC - 1));
  endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Dwell counter for the sweep driver: counts while enabled and raises tick on
// the last cycle of each dwell, wrapping back to zero on that cycle.
module sweep_dwell_timer #(
  parameter int DWELL = 20,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(DWELL - 1));

  // Next count: clear wins, then wrap on tick, else increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ques2_sweep_driver.sv
// Sweeps all 16 {A,B,C,D} vectors into QUES2, samples f at the end of each dwell
// and compares against a latched truth table. Option: QUES2_SWEEP_STOP_ON_ERR_EN.
module ques2_sweep_driver
  import ques2_pkg::*;
#(
  parameter int DWELL = 20,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_VEC-1:0]   exp_tt,
  input  logic                 f,
  output logic                 A,
  output logic                 B,
  output logic                 C,
  output logic                 D,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_VEC-1:0]   obs_tt,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [IDX_W-1:0]     fail_idx
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   abcd_q, abcd_d;
  logic [NUM_VEC-1:0] exp_q, exp_d;
  logic [NUM_VEC-1:0] obs_q, obs_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   fail_q, fail_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic accept_s;
  logic drive_s;
  logic tick_s;
  logic mismatch_s;
  logic stop_s;

  assign accept_s = start && (state_q != DRIVE);
  assign drive_s  = (state_q == DRIVE);

  sweep_dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_s),
    .en   (drive_s),
    .tick (tick_s)
  );

  // Mismatch on the current vector and the end-of-sweep decision.
  always_comb begin
    mismatch_s = (f != exp_q[idx_q]);
`ifdef QUES2_SWEEP_STOP_ON_ERR_EN
    stop_s = is_last_vec(idx_q) || mismatch_s;
`else
    stop_s = is_last_vec(idx_q);
`endif
  end

  // Sweep FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abcd_d  = abcd_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    err_d   = err_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          abcd_d  = '0;
          exp_d   = exp_tt;
          obs_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      DRIVE: begin
        if (tick_s) begin
          obs_d[idx_q] = f;
          if (mismatch_s) begin
            err_d = err_q + ERR_W'(1);
            if (err_q == ERR_W'(0)) begin
              fail_d = idx_q;
            end else begin
              fail_d = fail_q;
            end
          end else begin
            err_d = err_q;
          end
          if (stop_s) begin
            state_d = FIN;
            abcd_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            abcd_d = idx_q + IDX_W'(1);
          end
        end else begin
          abcd_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        abcd_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abcd_q  <= '0;
      exp_q   <= '0;
      obs_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abcd_q  <= abcd_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {A, B, C, D} = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign obs_tt       = obs_q;
  assign err_cnt      = err_q;
  assign fail_idx     = fail_q;

endmodule

// File: tb/tb_ques2_sweep_driver.sv
// Bench for ques2_sweep_driver: f is modelled as a truth table indexed by {A,B,C,D}.
module tb_ques2_sweep_driver;

  localparam int DWELL = 20;
  localparam int BOUND = 16 * DWELL + 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] exp_tt;
  logic        f;
  logic        A, B, C, D;
  logic        busy, done;
  logic [15:0] obs_tt;
  logic [4:0]  err_cnt;
  logic [3:0]  fail_idx;
  logic [15:0] ftt;

  int n_chk = 0;
  int n_err = 0;

  assign f = ftt[{A, B, C, D}];

  always #5 clk = ~clk;

  ques2_sweep_driver #(.DWELL(DWELL), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp_tt   (exp_tt),
    .f        (f),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .busy     (busy),
    .done     (done),
    .obs_tt   (obs_tt),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx)
  );

  function automatic int first_set(input logic [15:0] x);
    for (int i = 0; i < 16; i++) if (x[i]) return i;
    return 16;
  endfunction

  // Number of edges from the accepting edge until done rises.
  function automatic int sweep_len(input logic [15:0] t, input logic [15:0] e);
    int m;
    m = first_set(t ^ e);
`ifdef QUES2_SWEEP_STOP_ON_ERR_EN
    return (m < 16) ? (m + 1) * DWELL : 16 * DWELL;
`else
    return (m >= 0) ? 16 * DWELL : 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle/reset, 1 sweeping, 2 finished; k = edges since accept.
  int          ph = 0;
  int          k = 0;
  int          endk = 0;
  logic [15:0] ftt_l = 16'h0;
  logic [15:0] exp_l = 16'h0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0; k <= 0; endk <= 0; ftt_l <= 16'h0; exp_l <= 16'h0;
    end else if (start && ph != 1) begin
      ph <= 1; k <= 0; ftt_l <= ftt; exp_l <= exp_tt; endk <= sweep_len(ftt, exp_tt);
    end else if (ph == 1) begin
      k <= k + 1;
      if (k + 1 == endk) ph <= 2;
    end
  end

  always @(negedge clk) begin : cmp
    int          ns;
    logic [15:0] mask;
    logic [15:0] mism;
    if (chk_en) begin
      ns   = (ph == 1) ? k / DWELL : (ph == 2) ? endk / DWELL : 0;
      mask = (ns >= 16) ? 16'hFFFF : 16'((32'd1 << ns) - 32'd1);
      mism = (ftt_l ^ exp_l) & mask;
      check("busy", 32'(busy), 32'(ph == 1));
      check("done", 32'(done), 32'(ph == 2));
      check("abcd", 32'({A, B, C, D}), (ph == 1) ? 32'(k / DWELL) : 32'd0);
      check("obs_tt", 32'(obs_tt), 32'(ftt_l & mask));
      check("err_cnt", 32'(err_cnt), 32'($countones(mism)));
      check("fail_idx", 32'(fail_idx), (mism == 16'h0) ? 32'd0 : 32'(first_set(mism)));
    end
  end

  task automatic sweep(input logic [15:0] t, input logic [15:0] e, input int restart_at,
                       input int rst_at, input bit vecchk, output int n);
    ftt = t; exp_tt = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_done", 32'(done), 32'd0);
    check("accept_err", 32'(err_cnt), 32'd0);
    check("accept_obs", 32'(obs_tt), 32'd0);
    while (!done && n < BOUND) begin
      @(posedge clk); #1;
      n++;
      start = (n == restart_at);
      if (vecchk && (n == 220 || n == 239)) check("vec_b", 32'({A, B, C, D}), 32'hB);
      if (vecchk && n == 240) check("vec_c", 32'({A, B, C, D}), 32'hC);
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_abcd", 32'({A, B, C, D}), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_obs", 32'(obs_tt), 32'd0);
        return;
      end
    end
    start = 1'b0;
    n_chk++;
    if (!done) begin
      n_err++;
      $display("FAIL timeout: done not seen after %0d cycles", n);
    end
  endtask

  initial begin
    int          n;
    int          sel;
    int          rsta;
    logic [15:0] t;
    logic [15:0] e;
    rst = 1'b1; start = 1'b0; exp_tt = 16'h0; ftt = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_abcd", 32'({A, B, C, D}), 32'd0);
    check("reset_obs", 32'(obs_tt), 32'd0);
    check("reset_err", 32'(err_cnt), 32'd0);
    check("reset_fail", 32'(fail_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Parity function, matching table, ignored restart at cycle 100.
    sweep(16'h6996, 16'h6996, 100, -1, 1'b0, n);
    check("par_cycles", 32'(n), 32'd320);
    check("par_obs", 32'(obs_tt), 32'h6996);
    check("par_err", 32'(err_cnt), 32'd0);
    check("par_done", 32'(done), 32'd1);

    // Parity function, one wrong expected bit at vector 0.
    sweep(16'h6996, 16'h6997, -1, -1, 1'b0, n);
    check("p7_err", 32'(err_cnt), 32'd1);
    check("p7_fail", 32'(fail_idx), 32'd0);
`ifdef QUES2_SWEEP_STOP_ON_ERR_EN
    check("p7_cycles", 32'(n), 32'd20);
    check("p7_obs", 32'(obs_tt), 32'h0);
`else
    check("p7_cycles", 32'(n), 32'd320);
    check("p7_obs", 32'(obs_tt), 32'h6996);
`endif

    // f stuck at 0 against an all-ones table.
    sweep(16'h0000, 16'hFFFF, -1, -1, 1'b0, n);
    check("z_fail", 32'(fail_idx), 32'd0);
    check("z_obs", 32'(obs_tt), 32'h0);
`ifdef QUES2_SWEEP_STOP_ON_ERR_EN
    check("z_err", 32'(err_cnt), 32'd1);
    check("z_cycles", 32'(n), 32'd20);
`else
    check("z_err", 32'(err_cnt), 32'd16);
    check("z_cycles", 32'(n), 32'd320);
`endif

    // 4-input AND, with vector 0xB timing probe.
    sweep(16'h8000, 16'h8000, -1, -1, 1'b1, n);
    check("and_err", 32'(err_cnt), 32'd0);
    check("and_obs", 32'(obs_tt), 32'h8000);

    // Reset mid-sweep at cycle 150.
    sweep(16'h6996, 16'h6996, -1, 150, 1'b0, n);
    repeat (2) @(posedge clk);
    #1;

    // Randomized sweeps, mostly near-matching tables, occasional reset.
    repeat (10) begin
      t   = 16'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      e = t;
      else if (sel == 1) e = t ^ (16'h1 << $urandom_range(0, 15));
      else               e = 16'($urandom);
      rsta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300)) : -1;
      sweep(t, e, int'($urandom_range(1, 300)), rsta, 1'b0, n);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
